fifo_param: RTL
===============

FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_W, default 4, data width in bits (1..64).
REQ-002 Parameter DEPTH, default 8, entry count; power of two, 4..256; ADDR_W = log2(DEPTH).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  DATA_W  write data, sampled with push.
REQ-006 push  input  1  write request.
REQ-007 pop  input  1  read request.
REQ-008 umbral_af  input  ADDR_W+1  almost_full threshold (occupancy >= value).
REQ-009 umbral_ae  input  ADDR_W+1  almost_empty threshold (occupancy <= value).
REQ-010 data_out  output  DATA_W  registered read data.
REQ-011 valid_out  output  1  data_out holds the word popped on the previous edge.
REQ-012 count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  status flags, functions of count.
REQ-014 error  output  1  overflow/underflow indication.

Function
REQ-015 Pointers SHALL be ADDR_W+1 bits (wrap bit in MSB); full = pointers differ only in MSB, empty = pointers equal.
REQ-016 Accepted push (push and not full, or push and pop and full) SHALL write data_in at the write pointer and advance it modulo 2*DEPTH.
REQ-017 Accepted pop (pop and not empty) SHALL register mem[read pointer] into data_out on the same edge and advance the read pointer; valid_out = 1 for the following cycle only.
REQ-018 Read latency SHALL be one clock: pop at edge N -> data_out/valid_out valid after edge N.
REQ-019 Push and pop together when 0 < count < DEPTH SHALL both be accepted; count unchanged.
REQ-020 Push and pop together when full SHALL both be accepted (pop frees the slot); count stays DEPTH.
REQ-021 Push and pop together when empty: push accepted, pop rejected as underflow; count becomes 1.
REQ-022 Push when full without pop SHALL be dropped (no memory write, pointers held) and flag overflow.
REQ-023 Pop when empty SHALL be dropped (data_out held, valid_out = 0) and flag underflow.
REQ-024 count, full, empty, almost_full, almost_empty SHALL be registered and consistent with pointers after every edge (no one-cycle lag).
REQ-025 almost_full = (count >= umbral_af); almost_empty = (count <= umbral_ae); thresholds are sampled every cycle, and threshold values above DEPTH SHALL saturate to DEPTH.
REQ-026 data_out SHALL hold its last value when no pop is accepted.

Reset
REQ-027 Asserting reset SHALL immediately clear the pointers, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, error = 0, valid_out = 0, data_out = 0.
REQ-028 Memory contents SHALL NOT be reset; reset mid-operation discards all stored words.
REQ-029 push/pop asserted in the first edge after deassertion SHALL be processed normally.

Configuration
REQ-030 Macro FIFO_ERR_STICKY_EN defined: error SHALL latch to 1 on the first overflow/underflow and hold until reset.
REQ-031 Macro FIFO_ERR_STICKY_EN undefined: error SHALL be a one-cycle pulse in the cycle after each rejected push or pop.

Structure
REQ-032 Shared package fifo_pkg SHALL hold default DATA_W/DEPTH constants and the clog2-based ADDR_W helper function.
REQ-033 Storage SHALL be a sub-module dram_param (one write port, one registered read port, parameters DATA_W and DEPTH); pointer, flag and error logic stay in fifo_param.

Verification
REQ-034 Reset, then 8 pushes (0x1..0x8), DEPTH = 8 -> full = 1 and count = 8 after the 8th edge; a 9th push -> error, count stays 8.
REQ-035 From full, 8 pops -> data_out 0x1..0x8 in order, one cycle after each pop; empty = 1 after the last pop; a 9th pop -> error, valid_out = 0.
REQ-036 umbral_af = 6, umbral_ae = 1 -> almost_full rises on the edge where count reaches 6; almost_empty is 1 at count 0 and 1, and 0 at count 2.
REQ-037 Simultaneous push and pop at count 0, 4 and 8 -> count becomes 1, 4 and 8 respectively; underflow is flagged only at count 0.
REQ-038 Wrap test: 20 push/pop cycles at count 3 -> data order preserved across pointer wrap and no error.
REQ-039 Reset asserted asynchronously mid-burst -> outputs take their REQ-027 values before the next clock edge; run with FIFO_ERR_STICKY_EN both defined and undefined to check REQ-030/031.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and address-width helper for the parameterised FIFO.
package fifo_pkg;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 8;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/fifo_param_if.sv
// FIFO data/control/status bundle; master drives requests, slave is the FIFO.
interface fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int AW = addr_w(DEPTH);

  logic [DATA_W-1:0] data_in;
  logic              push;
  logic              pop;
  logic [AW:0]       umbral_af;
  logic [AW:0]       umbral_ae;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              error;

  modport master (
    output data_in, push, pop, umbral_af, umbral_ae,
    input  data_out, valid_out, count, full, empty, almost_full, almost_empty, error
  );

  modport slave (
    input  data_in, push, pop, umbral_af, umbral_ae,
    output data_out, valid_out, count, full, empty, almost_full, almost_empty, error
  );
endinterface

// File: rtl/dram_param.sv
// Storage for fifo_param: one write port, one registered read port (1-cycle latency).
// Array is not reset; only the read register clears.
module dram_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [addr_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       re,
  input  logic [addr_w(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-edge write to the slot being read returns the old word (full push+pop).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO, 1-cycle registered read; overflowing push / underflowing pop dropped and flagged.
// FIFO_ERR_STICKY_EN: error latches until reset; otherwise a one-cycle pulse per rejected request.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  fifo_param_if.slave  bus
);
  localparam int AW = addr_w(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [AW:0]       wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [AW:0]       count_r, count_n, af_thr, ae_thr;
  logic              full_r, empty_r, af_r, ae_r, err_r, vld_r;
  logic              push_ok, pop_ok, rej;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    pop_ok   = bus.pop && !empty_r;
    // A pop on a full FIFO frees the slot the push lands in.
    push_ok  = bus.push && (!full_r || pop_ok);
    rej      = (bus.push && !push_ok) || (bus.pop && !pop_ok);
    wr_ptr_n = wr_ptr + {{AW{1'b0}}, push_ok};
    rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop_ok};
    count_n  = count_r + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    af_thr   = (bus.umbral_af > DEPTH_V) ? DEPTH_V : bus.umbral_af;
    ae_thr   = (bus.umbral_ae > DEPTH_V) ? DEPTH_V : bus.umbral_ae;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      err_r   <= 1'b0;
      vld_r   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      count_r <= count_n;
      full_r  <= (wr_ptr_n ^ rd_ptr_n) == {1'b1, {AW{1'b0}}};
      empty_r <= (wr_ptr_n == rd_ptr_n);
      af_r    <= (count_n >= af_thr);
      ae_r    <= (count_n <= ae_thr);
      vld_r   <= pop_ok;
`ifdef FIFO_ERR_STICKY_EN
      err_r   <= err_r | rej;
`else
      err_r   <= rej;
`endif
    end
  end

  dram_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dram (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.data_in),
    .re    (pop_ok),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  assign bus.data_out     = rd_data;
  assign bus.valid_out    = vld_r;
  assign bus.count        = count_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.error        = err_r;
endmodule
